apb_master: RTL and testbench

Single-outstanding APB requester that drives the APB peripheral bus on one clock. It accepts read/write commands from an upstream controller over a valid/ready handshake and sequences them through APB SETUP and ACCESS phases. It waits on `pready` with a bounded timeout and returns one response per command carrying read data and an error flag. It is the direct upstream stage of every APB peripheral in the design.

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_wait_timer.sv | 31 +++
 rtl/apb_master.sv | 135 +++++++++++++
 tb/tb_apb_master.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester and its callers.
// The structs use the default widths; callers that override widths use flat ports.
package apb_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles; expired flags the last cycle the slave is allowed
// to take before the transfer is aborted.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;

    // count_reg holds the number of ACCESS cycles already spent without pready
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: one command in, one SETUP/ACCESS
// sequence on the bus, one response pulse out.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    apb_state_e state_reg, state_next;

    logic              idle_ready;
    logic              timer_expired;
    logic              xfer_done;
    logic              xfer_abort;
    logic              pwrite_reg;
    logic [ADDR_W-1:0] paddr_reg;
    logic [DATA_W-1:0] pwdata_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;
    logic              rsp_timeout_reg;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (state_reg == SETUP),
        .enable  (state_reg == ACCESS),
        .expired (timer_expired)
    );

    // pready on the expiring cycle wins over the abort
    assign xfer_done  = (state_reg == ACCESS) && pready;
    assign xfer_abort = (state_reg == ACCESS) && !pready && timer_expired;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (xfer_done || xfer_abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus controls decode straight from the state so reset drops them at once
    always_comb begin
        psel       = 1'b0;
        penable    = 1'b0;
        idle_ready = 1'b0;
        case (state_reg)
            IDLE:    idle_ready = 1'b1;
            SETUP:   psel = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: idle_ready = 1'b0;
        endcase
    end

    assign cmd_ready = idle_ready && presetn;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite_reg <= 1'b0;
            paddr_reg  <= '0;
            pwdata_reg <= '0;
        end else if ((state_reg == IDLE) && cmd_valid) begin
            pwrite_reg <= cmd_write;
            paddr_reg  <= cmd_addr;
            pwdata_reg <= cmd_wdata;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= xfer_done || xfer_abort;
            if (xfer_done) begin
                rsp_rdata_reg   <= pwrite_reg ? '0 : prdata;
                rsp_err_reg     <= pslverr;
                rsp_timeout_reg <= 1'b0;
            end else if (xfer_abort) begin
                rsp_rdata_reg   <= '0;
                rsp_err_reg     <= 1'b1;
                rsp_timeout_reg <= 1'b1;
            end
        end
    end

    assign pwrite      = pwrite_reg;
    assign paddr       = paddr_reg;
    assign pwdata      = pwdata_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios plus random commands against a
// transaction-level model of expected response, bus occupancy and slave memory.
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic [DW-1:0] prdata = '0;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [31:0] mem [16];

    apb_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One command end to end; the slave inserts 'waits' wait states, then answers
    task automatic do_txn(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                          input int waits, input logic err);
        int          exp_acc;
        logic        exp_to;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          psel_n;
        int          pen_n;
        int          cycles;
        logic        got;

        exp_to  = (waits + 1) > TO;
        exp_acc = exp_to ? TO : waits + 1;
        exp_err = exp_to || err;
        exp_rd  = (wr || exp_to) ? 32'h0 : mem[a];

        @(negedge pclk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = {28'd0, a};
        cmd_wdata = wd;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_write = ($urandom_range(0, 1) == 1);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;

        psel_n = 0;
        pen_n  = 0;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 64) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                if (psel) begin
                    psel_n++;
                    check("paddr_stable", paddr, {28'd0, a});
                    check("pwrite_stable", 32'(pwrite), 32'(wr));
                    check("pwdata_stable", pwdata, wd);
                    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                end
                if (penable) pen_n++;
                if (penable && pen_n == waits + 1) begin
                    pready  = 1'b1;
                    pslverr = err;
                    prdata  = wr ? $urandom : mem[a];
                    if (wr && !err) mem[a] = wd;
                end else begin
                    pready  = 1'b0;
                    pslverr = ($urandom_range(0, 1) == 1);
                    prdata  = $urandom;
                end
                @(negedge pclk);
                cycles++;
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;

        check("rsp_seen", 32'(got), 32'd1);
        if (got) begin
            check("rsp_rdata", rsp_rdata, exp_rd);
            check("rsp_err", 32'(rsp_err), 32'(exp_err));
            check("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
            check("psel_after", 32'(psel), 32'd0);
            check("cmd_ready_after", 32'(cmd_ready), 32'd1);
            check("psel_cycles", 32'(psel_n), 32'(exp_acc + 1));
            check("penable_cycles", 32'(pen_n), 32'(exp_acc));
            $display("txn %s addr=%0d wdata=%h waits=%0d slverr=%0d -> rdata=%h err=%0d timeout=%0d",
                     wr ? "WR" : "RD", a, wd, waits, err, rsp_rdata, rsp_err, rsp_timeout);
            @(negedge pclk);
            check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
            check("rsp_rdata_hold", rsp_rdata, exp_rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        // Reset held: everything idle, cmd_ready masked
        repeat (3) @(negedge pclk);
        check("rst_ctrl", {26'd0, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        presetn = 1'b1;
        #1;
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rel_psel", 32'(psel), 32'd0);

        do_txn(1'b1, 4'd2, 32'hDEAD_BEEF, 0, 1'b0);
        do_txn(1'b0, 4'd2, $urandom, 3, 1'b0);
        do_txn(1'b0, 4'd9, $urandom, 0, 1'b1);
        do_txn(1'b0, 4'd7, $urandom, 50, 1'b0);
        do_txn(1'b1, 4'd7, $urandom, 50, 1'b0);
        do_txn(1'b1, 4'd3, 32'hA5A5_0F0F, 3, 1'b0);
        do_txn(1'b0, 4'd3, $urandom, 3, 1'b0);

        // Reset during ACCESS: bus drops asynchronously, command is lost
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'd5;
        cmd_wdata = 32'h1234_5678;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("access_before_rst", 32'(penable), 32'd1);
        #2 presetn = 1'b0;
        #1;
        check("rst_async_psel", 32'(psel), 32'd0);
        check("rst_async_penable", 32'(penable), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        presetn = 1'b1;
        #1;
        check("rerel_cmd_ready", 32'(cmd_ready), 32'd1);
        do_txn(1'b1, 4'd5, 32'hCAFE_F00D, 1, 1'b0);
        do_txn(1'b0, 4'd5, $urandom, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            do_txn($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom,
                   int'($urandom_range(0, 6)), $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
